// File: rtl/vx_warp_fetch.sv
// Warp-scheduling fetch stage: per-warp PC/mask/active/waiting state,
// round-robin warp select and a registered F/D boundary towards decode.
module vx_warp_fetch #(
    parameter int          NW       = 2,
    parameter int          NT       = 2,
    parameter logic [31:0] START_PC = 32'h80000000,
    localparam int         WW       = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_stall,
    output logic [31:0]   out_icache_pc,
    input  logic [31:0]   in_icache_instruction,
    input  logic          in_branch_stall,
    input  logic [WW-1:0] in_decode_warp_num,
    input  logic          in_jal,
    input  logic [31:0]   in_jal_dest,
    input  logic [WW-1:0] in_jal_warp_num,
    input  logic          in_branch_valid,
    input  logic          in_branch_dir,
    input  logic [31:0]   in_branch_dest,
    input  logic [WW-1:0] in_branch_warp_num,
    input  logic          in_change_mask,
    input  logic [NT-1:0] in_thread_mask,
    input  logic          in_wspawn,
    input  logic [31:0]   in_wspawn_pc,
    input  logic          in_ebreak,
    output logic [31:0]   out_instruction,
    output logic [31:0]   out_curr_PC,
    output logic [NT-1:0] out_valid,
    output logic [WW-1:0] out_warp_num,
    output logic          out_all_done
);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]   pc_q [NW];
    logic [31:0]   pc_d [NW];
    logic [NT-1:0] mask_q [NW];
    logic [NT-1:0] mask_d [NW];
    logic [NW-1:0] active_q, active_d;
    logic [NW-1:0] waiting_q, waiting_d;
    logic [WW-1:0] last_q, last_d;

    logic [31:0]   ins_q, ins_d;
    logic [31:0]   opc_q, opc_d;
    logic [NT-1:0] valid_q, valid_d;
    logic [WW-1:0] wnum_q, wnum_d;

    logic [NW-1:0] elig;
    logic [WW-1:0] sel;
    logic          found;
    logic          issue;
    int            idx;

    // Decode's branch stall hides its warp in the same cycle it is flagged.
    always_comb begin
        for (int w = 0; w < NW; w++) begin
            elig[w] = active_q[w] && !waiting_q[w] &&
                      !(in_branch_stall && in_decode_warp_num == WW'(w));
        end
    end

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NW; i++) begin
            idx = (int'(last_q) + i) % NW;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = WW'(idx);
            end
        end
    end

    assign issue         = !in_stall && found;
    assign out_icache_pc = pc_q[sel];
    assign out_all_done  = ~|active_q;

    // Later assignments override earlier ones: lowest priority first.
    always_comb begin
        active_d  = active_q;
        waiting_d = waiting_q;
        for (int w = 0; w < NW; w++) begin
            pc_d[w]   = pc_q[w];
            mask_d[w] = mask_q[w];
            if (issue && sel == WW'(w))
                pc_d[w] = pc_q[w] + 32'd4;
            if (in_change_mask && in_decode_warp_num == WW'(w)) begin
                mask_d[w] = in_thread_mask;
                if (in_thread_mask == '0)
                    active_d[w] = 1'b0;
            end
            if (in_wspawn && !active_q[w] && in_decode_warp_num != WW'(w)) begin
                active_d[w]  = 1'b1;
                pc_d[w]      = in_wspawn_pc;
                mask_d[w]    = NT'(1);
                waiting_d[w] = 1'b0;
            end
            if (in_branch_stall && in_decode_warp_num == WW'(w))
                waiting_d[w] = 1'b1;
            if (in_jal && in_jal_warp_num == WW'(w)) begin
                pc_d[w]      = in_jal_dest;
                waiting_d[w] = 1'b0;
            end
            if (in_branch_valid && in_branch_warp_num == WW'(w)) begin
                waiting_d[w] = 1'b0;
                if (in_branch_dir)
                    pc_d[w] = in_branch_dest;
            end
            if (in_ebreak && in_decode_warp_num == WW'(w)) begin
                active_d[w]  = 1'b0;
                waiting_d[w] = 1'b0;
            end
        end
    end

    always_comb begin
        last_d  = last_q;
        ins_d   = ins_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        wnum_d  = wnum_q;
        if (issue) begin
            last_d  = sel;
            ins_d   = in_icache_instruction;
            opc_d   = pc_q[sel];
            valid_d = mask_q[sel];
            wnum_d  = sel;
        end else if (!in_stall) begin
            ins_d   = NOP;
            opc_d   = '0;
            valid_d = '0;
            wnum_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                pc_q[w]   <= (w == 0) ? START_PC : 32'd0;
                mask_q[w] <= (w == 0) ? NT'(1) : '0;
            end
            active_q  <= NW'(1);
            waiting_q <= '0;
            last_q    <= WW'(NW - 1);
            ins_q     <= NOP;
            opc_q     <= '0;
            valid_q   <= '0;
            wnum_q    <= '0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                pc_q[w]   <= pc_d[w];
                mask_q[w] <= mask_d[w];
            end
            active_q  <= active_d;
            waiting_q <= waiting_d;
            last_q    <= last_d;
            ins_q     <= ins_d;
            opc_q     <= opc_d;
            valid_q   <= valid_d;
            wnum_q    <= wnum_d;
        end
    end

    assign out_instruction = ins_q;
    assign out_curr_PC     = opc_q;
    assign out_valid       = valid_q;
    assign out_warp_num    = wnum_q;
endmodule

// File: tb/tb_vx_warp_fetch.sv
// Directed bench for vx_warp_fetch: expected F/D outputs are queued
// as each cycle is driven and checked after the following edge.
module tb_vx_warp_fetch;
    localparam logic [31:0] KEY = 32'h5A5A0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_stall;
    logic [31:0] out_icache_pc;
    logic [31:0] in_icache_instruction;
    logic        in_branch_stall;
    logic [0:0]  in_decode_warp_num;
    logic        in_jal;
    logic [31:0] in_jal_dest;
    logic [0:0]  in_jal_warp_num;
    logic        in_branch_valid;
    logic        in_branch_dir;
    logic [31:0] in_branch_dest;
    logic [0:0]  in_branch_warp_num;
    logic        in_change_mask;
    logic [1:0]  in_thread_mask;
    logic        in_wspawn;
    logic [31:0] in_wspawn_pc;
    logic        in_ebreak;
    logic [31:0] out_instruction;
    logic [31:0] out_curr_PC;
    logic [1:0]  out_valid;
    logic [0:0]  out_warp_num;
    logic        out_all_done;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [1:0]  v;
        logic [0:0]  w;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: contents derived from the address.
    assign in_icache_instruction = out_icache_pc ^ KEY;

    vx_warp_fetch #(.NW(2), .NT(2), .START_PC(32'h80000000)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_stall             (in_stall),
        .out_icache_pc        (out_icache_pc),
        .in_icache_instruction(in_icache_instruction),
        .in_branch_stall      (in_branch_stall),
        .in_decode_warp_num   (in_decode_warp_num),
        .in_jal               (in_jal),
        .in_jal_dest          (in_jal_dest),
        .in_jal_warp_num      (in_jal_warp_num),
        .in_branch_valid      (in_branch_valid),
        .in_branch_dir        (in_branch_dir),
        .in_branch_dest       (in_branch_dest),
        .in_branch_warp_num   (in_branch_warp_num),
        .in_change_mask       (in_change_mask),
        .in_thread_mask       (in_thread_mask),
        .in_wspawn            (in_wspawn),
        .in_wspawn_pc         (in_wspawn_pc),
        .in_ebreak            (in_ebreak),
        .out_instruction      (out_instruction),
        .out_curr_PC          (out_curr_PC),
        .out_valid            (out_valid),
        .out_warp_num         (out_warp_num),
        .out_all_done         (out_all_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic exp_issue(input logic [31:0] pc, input logic [1:0] v,
                             input logic w, input logic done);
        exp_t e;
        e.ins = pc ^ KEY; e.pc = pc; e.v = v; e.w = w; e.done = done;
        sb.push_back(e);
    endtask

    task automatic exp_bubble(input logic done);
        exp_t e;
        e.ins = 32'h00000013; e.pc = '0; e.v = '0; e.w = '0; e.done = done;
        sb.push_back(e);
    endtask

    task automatic clear_fb;
        in_branch_stall    = 0;
        in_decode_warp_num = 0;
        in_jal             = 0;
        in_jal_dest        = 0;
        in_jal_warp_num    = 0;
        in_branch_valid    = 0;
        in_branch_dir      = 0;
        in_branch_dest     = 0;
        in_branch_warp_num = 0;
        in_change_mask     = 0;
        in_thread_mask     = 0;
        in_wspawn          = 0;
        in_wspawn_pc       = 0;
        in_ebreak          = 0;
    endtask

    // One clock: sample outputs after the edge, check, then drop pulses.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".ins"},  out_instruction, e.ins);
            chk({tag, ".pc"},   out_curr_PC, e.pc);
            chk({tag, ".v"},    32'(out_valid), 32'(e.v));
            chk({tag, ".w"},    32'(out_warp_num), 32'(e.w));
            chk({tag, ".done"}, 32'(out_all_done), 32'(e.done));
        end
        clear_fb();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; in_stall = 0; clear_fb();
        exp_bubble(0); tick("rst");
        reset = 0;
        exp_issue(32'h80000000, 2'b01, 0, 0); tick("boot0");
        exp_issue(32'h80000004, 2'b01, 0, 0); tick("boot1");
        exp_issue(32'h80000008, 2'b01, 0, 0); tick("boot2");

        in_branch_stall = 1;
        exp_bubble(0); tick("jal_stall");
        exp_bubble(0); tick("jal_wait");
        in_jal = 1; in_jal_dest = 32'h80000100;
        exp_bubble(0); tick("jal_res");
        exp_issue(32'h80000100, 2'b01, 0, 0); tick("jal_tgt");
        exp_issue(32'h80000104, 2'b01, 0, 0); tick("jal_tgt4");

        in_branch_stall = 1;
        exp_bubble(0); tick("bnt_stall");
        in_branch_valid = 1; in_branch_dir = 0;
        in_branch_dest = 32'h80000500;
        exp_bubble(0); tick("bnt_res");
        exp_issue(32'h80000108, 2'b01, 0, 0); tick("bnt_next");

        in_branch_stall = 1;
        exp_bubble(0); tick("bt_stall");
        in_branch_valid = 1; in_branch_dir = 1;
        in_branch_dest = 32'h80000300;
        exp_bubble(0); tick("bt_res");
        exp_issue(32'h80000300, 2'b01, 0, 0); tick("bt_tgt");

        in_wspawn = 1; in_wspawn_pc = 32'h80000200;
        exp_issue(32'h80000304, 2'b01, 0, 0); tick("sp0");
        exp_issue(32'h80000200, 2'b01, 1, 0); tick("sp1");
        exp_issue(32'h80000308, 2'b01, 0, 0); tick("sp2");
        exp_issue(32'h80000204, 2'b01, 1, 0); tick("sp3");
        exp_issue(32'h8000030C, 2'b01, 0, 0); tick("sp4");

        in_change_mask = 1; in_decode_warp_num = 0; in_thread_mask = 2'b11;
        exp_issue(32'h80000208, 2'b01, 1, 0); tick("mk0");
        exp_issue(32'h80000310, 2'b11, 0, 0); tick("mk1");
        exp_issue(32'h8000020C, 2'b01, 1, 0); tick("mk2");
        in_change_mask = 1; in_decode_warp_num = 1; in_thread_mask = 2'b00;
        exp_issue(32'h80000314, 2'b11, 0, 0); tick("mk_off");
        exp_issue(32'h80000318, 2'b11, 0, 0); tick("mk_solo0");
        exp_issue(32'h8000031C, 2'b11, 0, 0); tick("mk_solo1");

        in_stall = 1;
        for (int i = 0; i < 3; i++) begin
            exp_issue(32'h8000031C, 2'b11, 0, 0); tick("stall_hold");
        end
        in_stall = 0;
        exp_issue(32'h80000320, 2'b11, 0, 0); tick("stall_resume");

        in_ebreak = 1; in_decode_warp_num = 0;
        exp_issue(32'h80000324, 2'b11, 0, 1); tick("ebrk");
        exp_bubble(1); tick("ebrk_b0");
        exp_bubble(1); tick("ebrk_b1");

        reset = 1; in_jal = 1; in_jal_dest = 32'h12345678;
        in_wspawn = 1; in_wspawn_pc = 32'h80000200;
        exp_bubble(0); tick("rst2");
        reset = 0;
        exp_issue(32'h80000000, 2'b01, 0, 0); tick("reboot0");
        exp_issue(32'h80000004, 2'b01, 0, 0); tick("reboot1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
